// File: rtl/rca4_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rca4_seq_ctrl
//
// Purpose:
//   Multi-word adder controller. It accepts two NIBBLES*4-bit operands and a
//   carry-in over a valid/ready handshake. It then steps a single 4-bit ripple
//   carry adder (rca4) through the operands one nibble per cycle, LSB first.
//   The carry-out of each nibble feeds the carry-in of the next. The finished
//   result is held on the output until the consumer accepts it.
//
// Parameters:
//   NIBBLES     operand width in nibbles, W = 4*NIBBLES (1..16)
//
// Ports:
//   _clk        in   1  clock, all state on rising edge
//   _rst        in   1  synchronous reset, active-high
//   _in_valid   in   1  operand request valid
//   _in_ready   out  1  controller can accept a request (IDLE only)
//   _a          in   W  operand A, sampled on input handshake
//   _b          in   W  operand B, sampled on input handshake
//   _cin        in   1  carry-in to nibble 0, sampled on input handshake
//   _out_valid  out  1  result valid
//   _out_ready  in   1  consumer accepts result
//   _sum        out  W  A+B+cin, low W bits
//   _cout       out  1  carry out of the MSB nibble
//   _ovf        out  1  signed overflow of the addition
//   _busy       out  1  high while adding or holding a result
//
// File also contains rca4, the 4-bit ripple carry adder used per nibble.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// rca4: purely combinational 4-bit ripple carry adder.
//   _a, _b  in  4  addends
//   _cin    in  1  carry-in
//   _s      out 4  sum
//   _cout   out 1  carry-out
// ----------------------------------------------------------------------------
module rca4 (
    input  logic [3:0] _a,
    input  logic [3:0] _b,
    input  logic       _cin,
    output logic [3:0] _s,
    output logic       _cout
);

    logic [4:0] carry;

    // Four chained full adders; carry[i] is the carry into bit i.
    always_comb begin
        carry    = '0;
        _s       = '0;
        carry[0] = _cin;
        for (int i = 0; i < 4; i++) begin
            _s[i]      = _a[i] ^ _b[i] ^ carry[i];
            carry[i+1] = (_a[i] & _b[i]) | (carry[i] & (_a[i] ^ _b[i]));
        end
        _cout = carry[4];
    end

endmodule

module rca4_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 _clk,
    input  logic                 _rst,
    input  logic                 _in_valid,
    output logic                 _in_ready,
    input  logic [4*NIBBLES-1:0] _a,
    input  logic [4*NIBBLES-1:0] _b,
    input  logic                 _cin,
    output logic                 _out_valid,
    input  logic                 _out_ready,
    output logic [4*NIBBLES-1:0] _sum,
    output logic                 _cout,
    output logic                 _ovf,
    output logic                 _busy
);

    localparam int W  = 4 * NIBBLES;
    // Nibble index needs at least one bit even when there is a single nibble.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
    localparam logic [W-1:0]  NIB_MASK = W'(4'hF);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  acc_reg;
    logic          carry_reg;
    logic [IW-1:0] idx;

    logic          out_valid_reg;
    logic [W-1:0]  sum_reg;
    logic          cout_reg;
    logic          ovf_reg;

    logic          accept;
    logic          release_result;
    logic          last_nibble;
    logic [IW+1:0] shamt;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_cout;

    assign accept         = _in_valid & _in_ready;
    assign release_result = out_valid_reg & _out_ready;
    assign last_nibble    = (idx == LAST_IDX);

    // Bit offset of the current nibble; shifting avoids a variable part-select.
    assign shamt = {idx, 2'b00};
    assign nib_a = 4'(a_reg >> shamt);
    assign nib_b = 4'(b_reg >> shamt);

    rca4 u_rca4 (
        ._a    (nib_a),
        ._b    (nib_b),
        ._cin  (carry_reg),
        ._s    (nib_s),
        ._cout (nib_cout)
    );

    // State register.
    always_ff @(posedge _clk) begin
        if (_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. DONE is left only after the result has been presented
    // (out_valid high) and the consumer takes it.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept)         next_state = ADD;
            ADD:  if (last_nibble)    next_state = DONE;
            DONE: if (release_result) next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Working datapath: operands are captured on accept, then one nibble of
    // the accumulator is filled in per ADD cycle while the carry ripples
    // forward through carry_reg.
    always_ff @(posedge _clk) begin
        if (_rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= _a;
                        b_reg     <= _b;
                        carry_reg <= _cin;
                        idx       <= '0;
                    end
                end
                ADD: begin
                    acc_reg   <= (acc_reg & ~(NIB_MASK << shamt)) | (W'(nib_s) << shamt);
                    carry_reg <= nib_cout;
                    if (!last_nibble) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result stage. The first DONE cycle commits the finished accumulator to
    // the output registers and raises out_valid one cycle later. This gives a
    // latency of NIBBLES+1 cycles from accept. The outputs then hold their
    // value through IDLE until the next commit.
    always_ff @(posedge _clk) begin
        if (_rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (state == DONE) begin
            if (!out_valid_reg) begin
                out_valid_reg <= 1'b1;
                sum_reg       <= acc_reg;
                cout_reg      <= carry_reg;
                ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) && (acc_reg[W-1] != a_reg[W-1]);
            end else if (_out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign _in_ready  = (state == IDLE);
    assign _busy      = (state == ADD) || (state == DONE);
    assign _out_valid = out_valid_reg;
    assign _sum       = sum_reg;
    assign _cout      = cout_reg;
    assign _ovf       = ovf_reg;

endmodule

// File: tb/tb_rca4_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rca4_seq_ctrl
//
// Purpose:
//   Self-checking bench for rca4_seq_ctrl with NIBBLES=4. Expected results are
//   computed from a plain 17-bit addition and queued when operands are
//   accepted. They are popped and compared when the controller presents a
//   result. The bench also exercises reset, latency, backpressure and reset in
//   the middle of an addition.
// ----------------------------------------------------------------------------
module tb_rca4_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int LATENCY = NIBBLES + 1;
    localparam int TIMEOUT = 50;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } result_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         cin;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    result_t      scoreboard[$];
    int           testCount = 0;
    int           failCount = 0;

    rca4_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        ._clk       (clk),
        ._rst       (rst),
        ._in_valid  (inValid),
        ._in_ready  (inReady),
        ._a         (opA),
        ._b         (opB),
        ._cin       (cin),
        ._out_valid (outValid),
        ._out_ready (outReady),
        ._sum       (sum),
        ._cout      (cout),
        ._ovf       (ovf),
        ._busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain wide addition.
    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c);
        result_t     r;
        logic [W:0]  full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    // Runs one full transaction. The expected result is queued on accept and
    // popped when out_valid rises. The result is then held for holdCycles
    // while new (ignored) operands are offered, and finally released.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input int holdCycles);
        int      waited;
        result_t exp;

        waited = 0;
        while (!inReady && waited < TIMEOUT) begin
            tick;
            waited++;
        end
        if (!inReady) begin
            checkOutput("in_ready_timeout", 32'(inReady), 32'd1);
            return;
        end

        opA     = a;
        opB     = b;
        cin     = c;
        inValid = 1'b1;
        scoreboard.push_back(model(a, b, c));
        tick;
        inValid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("in_ready_in_add", 32'(inReady), 32'd0);

        waited = 0;
        while (!outValid && waited < TIMEOUT) begin
            tick;
            waited++;
        end
        if (!outValid) begin
            checkOutput("out_valid_timeout", 32'(outValid), 32'd1);
            void'(scoreboard.pop_front());
            return;
        end
        checkOutput("latency", 32'(waited), 32'(LATENCY));

        if (scoreboard.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        exp = scoreboard.pop_front();
        checkOutput("sum", 32'(sum), 32'(exp.sum));
        checkOutput("cout", 32'(cout), 32'(exp.cout));
        checkOutput("ovf", 32'(ovf), 32'(exp.ovf));

        for (int i = 0; i < holdCycles; i++) begin
            opA     = W'($urandom);
            opB     = W'($urandom);
            cin     = 1'($urandom);
            inValid = 1'b1;
            tick;
            checkOutput("hold_out_valid", 32'(outValid), 32'd1);
            checkOutput("hold_sum", 32'(sum), 32'(exp.sum));
            checkOutput("hold_in_ready", 32'(inReady), 32'd0);
        end
        inValid = 1'b0;

        outReady = 1'b1;
        tick;
        outReady = 1'b0;
        checkOutput("release_out_valid", 32'(outValid), 32'd0);
        checkOutput("release_in_ready", 32'(inReady), 32'd1);
        checkOutput("release_busy", 32'(busy), 32'd0);
        checkOutput("idle_keeps_sum", 32'(sum), 32'(exp.sum));
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        opA      = '0;
        opB      = '0;
        cin      = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(inReady), 32'd1);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'h0000);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);

        applyStimulus(16'h0001, 16'h0002, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 0);

        // Backpressure: result held for 10 cycles while new requests are offered.
        applyStimulus(16'h1234, 16'h4321, 1'b0, 10);

        // Reset during the second ADD cycle discards the operation.
        opA     = 16'hABCD;
        opB     = 16'h1111;
        cin     = 1'b1;
        inValid = 1'b1;
        scoreboard.push_back(model(16'hABCD, 16'h1111, 1'b1));
        tick;
        inValid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        void'(scoreboard.pop_back());
        checkOutput("midadd_reset_in_ready", 32'(inReady), 32'd1);
        checkOutput("midadd_reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("midadd_reset_sum", 32'(sum), 32'h0000);
        checkOutput("midadd_reset_busy", 32'(busy), 32'd0);

        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 0);

        for (int n = 0; n < 6; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), n % 3);
        end

        checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
